// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS pipeline stages
// Holds the reset PC, the nop encoding and the 5-bit exception codes.
package mips_pkg;

  typedef logic [4:0] exc_code_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0000_3000;
  localparam int          IMEM_WORDS_DEFAULT = 4096;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: PC loop, hazard controls, imem port, F/D outputs
// master = surrounding pipeline and instruction memory, slave = fetch_stage.
interface fetch_stage_if;
  import mips_pkg::*;

  logic [31:0] next_pc;
  logic        stall;
  logic        flush_D;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] instr_D;
  logic        valid_D;
  exc_code_t   exc_code_D;

  modport master (
    output next_pc, stall, flush_D, imem_rdata,
    input  imem_addr, PC_F, PC_D, instr_D, valid_D, exc_code_D
  );

  modport slave (
    input  next_pc, stall, flush_D, imem_rdata,
    output imem_addr, PC_F, PC_D, instr_D, valid_D, exc_code_D
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - fetch PC register with load enable and sync active-low reset
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [31:0] i_next,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (i_en) begin
      r_pc <= i_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, imem address, F/D pipeline register
// Optional FETCH_EXC_EN adds AdEL detection for misaligned or out-of-range fetch PCs.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  fetch_stage_if.slave bus
);

  logic [31:0] w_pc_f;
  logic [31:0] w_fetch_instr;
  exc_code_t   w_fetch_exc;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  exc_code_t   r_exc_code_d;

  // A stall holds the PC even when flush_D clears F/D, so nothing is fetched twice.
  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .i_en   (!bus.stall),
    .i_next (bus.next_pc),
    .o_pc   (w_pc_f)
  );

`ifdef FETCH_EXC_EN
  // 33-bit limit so a window ending at 4 GiB cannot wrap to zero.
  localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) * 33'd4);

  logic w_misaligned;
  logic w_out_of_range;
  logic w_adel;

  assign w_misaligned   = |w_pc_f[1:0];
  assign w_out_of_range = (w_pc_f < IMEM_BASE) || ({1'b0, w_pc_f} >= IMEM_LIMIT);
  assign w_adel         = w_misaligned || w_out_of_range;
  assign w_fetch_exc    = w_adel ? EXC_ADEL : EXC_NONE;
  assign w_fetch_instr  = w_adel ? NOP_INSTR : bus.imem_rdata;
`else
  assign w_fetch_exc    = EXC_NONE;
  assign w_fetch_instr  = bus.imem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!reset || bus.flush_D) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'h0;
      r_valid_d    <= 1'b0;
      r_exc_code_d <= EXC_NONE;
    end else if (!bus.stall) begin
      r_instr_d    <= w_fetch_instr;
      r_pc_d       <= w_pc_f;
      r_valid_d    <= 1'b1;
      r_exc_code_d <= w_fetch_exc;
    end
  end

  assign bus.imem_addr  = w_pc_f;
  assign bus.PC_F       = w_pc_f;
  assign bus.PC_D       = r_pc_d;
  assign bus.instr_D    = r_instr_d;
  assign bus.valid_D    = r_valid_d;
  assign bus.exc_code_D = r_exc_code_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: reference model plus directed vectors
module tb_fetch_stage;

`ifdef FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  // Fetch exception a PC must raise: misaligned, or outside [0x3000, 0x7000).
  function automatic logic [4:0] exp_exc(input logic [31:0] pc);
    if (!EXC_EN) return 5'd0;
    if (pc % 4 != 0 || pc < 32'h3000 || pc >= 32'h3000 + 4 * 4096) return 5'd4;
    return 5'd0;
  endfunction

  logic [31:0] m_pc_f, m_pc_d, m_instr_d;
  logic        m_valid_d;
  logic [4:0]  m_exc_d;
  logic        m_known = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc_f    <= 32'h3000;
      m_pc_d    <= 32'h0;
      m_instr_d <= 32'h0;
      m_valid_d <= 1'b0;
      m_exc_d   <= 5'd0;
      m_known   <= 1'b1;
    end else begin
      if (!bus.stall) m_pc_f <= bus.next_pc;
      if (bus.flush_D) begin
        m_pc_d    <= 32'h0;
        m_instr_d <= 32'h0;
        m_valid_d <= 1'b0;
        m_exc_d   <= 5'd0;
      end else if (!bus.stall) begin
        m_pc_d    <= m_pc_f;
        m_instr_d <= (exp_exc(m_pc_f) != 5'd0) ? 32'h0 : imem_word(m_pc_f);
        m_valid_d <= 1'b1;
        m_exc_d   <= exp_exc(m_pc_f);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("model PC_F",       bus.PC_F,       m_pc_f);
      chk("model imem_addr",  bus.imem_addr,  m_pc_f);
      chk("model PC_D",       bus.PC_D,       m_pc_d);
      chk("model instr_D",    bus.instr_D,    m_instr_d);
      chk("model valid_D",    32'(bus.valid_D),    32'(m_valid_d));
      chk("model exc_code_D", 32'(bus.exc_code_D), 32'(m_exc_d));
    end
  end

  task automatic d(input logic rst, input logic stl, input logic fl, input logic [31:0] np);
    reset       = rst;
    bus.stall   = stl;
    bus.flush_D = fl;
    bus.next_pc = np;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] ins,
                     input logic vld, input logic [4:0] exc);
    chk("lit PC_F",       bus.PC_F,       pcf);
    chk("lit PC_D",       bus.PC_D,       pcd);
    chk("lit instr_D",    bus.instr_D,    ins);
    chk("lit valid_D",    32'(bus.valid_D),    32'(vld));
    chk("lit exc_code_D", 32'(bus.exc_code_D), 32'(exc));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    d(1'b0, 1'b0, 1'b0, 32'h0);
    d(1'b0, 1'b0, 1'b0, 32'h0);
    lit(32'h3000, 32'h0, 32'h0, 1'b0, 5'd0);

    d(1'b1, 1'b0, 1'b0, 32'h3004);
    lit(32'h3004, 32'h3000, 32'h3000_CFFF, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3008);
    lit(32'h3008, 32'h3004, 32'h3004_CFFB, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h300C);
    lit(32'h300C, 32'h3008, 32'h3008_CFF7, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3010);
    lit(32'h3010, 32'h300C, 32'h300C_CFF3, 1'b1, 5'd0);

    for (int i = 0; i < 3; i++) begin
      d(1'b1, 1'b1, 1'b0, 32'hDEAD_0000);
      lit(32'h3010, 32'h300C, 32'h300C_CFF3, 1'b1, 5'd0);
    end
    d(1'b1, 1'b0, 1'b0, 32'h3014);
    lit(32'h3014, 32'h3010, 32'h3010_CFEF, 1'b1, 5'd0);

    d(1'b1, 1'b1, 1'b1, 32'hDEAD_0000);
    lit(32'h3014, 32'h0, 32'h0, 1'b0, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3018);
    lit(32'h3018, 32'h3014, 32'h3014_CFEB, 1'b1, 5'd0);

    d(1'b1, 1'b0, 1'b0, 32'h3400);
    lit(32'h3400, 32'h3018, 32'h3018_CFE7, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3404);
    lit(32'h3404, 32'h3400, 32'h3400_CBFF, 1'b1, 5'd0);

    d(1'b1, 1'b0, 1'b0, 32'h3002);
    lit(32'h3002, 32'h3404, 32'h3404_CBFB, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h0100);
    lit(32'h0100, 32'h3002, EXC_EN ? 32'h0 : 32'h3002_CFFD, 1'b1, EXC_EN ? 5'd4 : 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h6FFC);
    lit(32'h6FFC, 32'h0100, EXC_EN ? 32'h0 : 32'h0100_FEFF, 1'b1, EXC_EN ? 5'd4 : 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h7000);
    lit(32'h7000, 32'h6FFC, 32'h6FFC_9003, 1'b1, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3020);
    lit(32'h3020, 32'h7000, EXC_EN ? 32'h0 : 32'h7000_8FFF, 1'b1, EXC_EN ? 5'd4 : 5'd0);

    d(1'b1, 1'b1, 1'b0, 32'hDEAD_0000);
    lit(32'h3020, 32'h7000, EXC_EN ? 32'h0 : 32'h7000_8FFF, 1'b1, EXC_EN ? 5'd4 : 5'd0);
    d(1'b0, 1'b1, 1'b0, 32'hDEAD_0000);
    lit(32'h3000, 32'h0, 32'h0, 1'b0, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h3004);
    lit(32'h3004, 32'h3000, 32'h3000_CFFF, 1'b1, 5'd0);

    d(1'b1, 1'b0, 1'b1, 32'h3008);
    lit(32'h3008, 32'h0, 32'h0, 1'b0, 5'd0);
    d(1'b1, 1'b0, 1'b0, 32'h300C);
    lit(32'h300C, 32'h3008, 32'h3008_CFF7, 1'b1, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the architectural fetch PC (`PC_F`), drives the instruction-memory address, and registers the fetched word into the F/D pipeline register (`instr_D`, `PC_D`). It consumes `next_pc` from the next-PC logic and feeds `PC_F`/`PC_D` back to it, closing the PC loop. It honours the hazard unit's stall and the D-stage flush.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `IMEM_BASE`, 32'h0000_3000, lowest legal instruction address.
- `IMEM_WORDS`, 4096, instruction memory depth in words.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `next_pc`  in  32  next fetch address from the next-PC logic.
- `stall`  in  1  hazard unit: hold `PC_F` and the F/D register.
- `flush_D`  in  1  replace F/D contents with a bubble.
- `imem_addr`  out  32  instruction memory address, equal to `PC_F`.
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`.
- `PC_F`  out  32  current fetch PC.
- `PC_D`  out  32  PC of the instruction in D.
- `instr_D`  out  32  instruction in D.
- `valid_D`  out  1  D holds a real instruction (0 = bubble).
- `exc_code_D`  out  5  fetch exception code of the D instruction (0 = none).

## Operation
- PC register: reset gives `PC_F = RESET_PC`. Otherwise on each edge, `PC_F <= next_pc` when `!stall`, and holds when `stall`.
- `imem_addr = PC_F`, combinational.
- F/D register priority: reset > flush_D > stall > load.
  - Reset or flush gives `instr_D = 32'h0` (nop), `PC_D = 32'h0`, `valid_D = 0`, `exc_code_D = 0`.
  - Stall holds all F/D outputs.
  - Load captures `instr_D <= fetched word`, `PC_D <= PC_F`, `valid_D <= 1`, `exc_code_D <= fetch exception`.
- Flush with stall asserted: F/D still clears and `PC_F` still holds. No instruction is re-fetched twice.
- The branch delay slot is architectural, so the hazard unit never asserts `flush_D` for taken branches or jumps. `flush_D` is reserved for exception/eret redirection.
- `next_pc` is a pure function of `PC_F`/`PC_D` plus D-stage state. This block adds no arithmetic on it and never adds 4 itself.

## Timing
- Fetch latency: 1 cycle. The word at `PC_F` in cycle n appears on `instr_D` in cycle n+1.
- Registered outputs: `PC_F`, `PC_D`, `instr_D`, `valid_D`, `exc_code_D`. The only combinational output is `imem_addr`.
- Reset mid-operation: on the first edge with `reset = 0`, every register takes its reset value, regardless of `stall` or `flush_D`.
- Reset release: the first fetch is `RESET_PC`. `valid_D` rises one cycle after the first edge with reset deasserted.
- Multi-cycle stall: outputs are frozen for exactly the stalled edges. The cycle after `stall` falls, `PC_F = next_pc` sampled at that edge.

## Configuration
- `FETCH_EXC_EN` defined: the fetch raises AdEL (`exc_code = 5'd4`) in either of these cases:
  - `PC_F[1:0] != 0`.
  - `PC_F < IMEM_BASE` or `PC_F >= IMEM_BASE + 4*IMEM_WORDS`.
  
  A faulting fetch loads `instr_D = 0` and keeps `PC_D = PC_F`, with `valid_D = 1`.
- `FETCH_EXC_EN` undefined: `exc_code_D` is constant 0 and `imem_rdata` is always captured unchanged. No range comparators are synthesised.

## Structure
- Shared package `mips_pkg`: `RESET_PC_DEFAULT`, `NOP_INSTR`, exception code constants (`EXC_NONE = 0`, `EXC_ADEL = 4`), and the 5-bit exception code typedef.
- One sub-module, `pc_reg`: a 32-bit register with enable (`!stall`) and reset value `RESET_PC`.
- The F/D register and the fetch-exception logic stay in `fetch_stage`.

## Test plan
- Reset held 2 cycles, then released with `next_pc = PC_F + 4` -> `PC_F` steps 0x3000, 0x3004, 0x3008. `PC_D`/`instr_D` trail by one cycle, and `valid_D = 0` in the first cycle after release.
- Stall asserted 3 cycles at `PC_F = 0x3010` -> `PC_F`, `PC_D`, `instr_D` frozen for 3 cycles. After release `PC_F = 0x3014`, with no duplicate or skipped instruction.
- `flush_D` and `stall` asserted together -> `instr_D = 0`, `valid_D = 0`, `PC_D = 0`, and `PC_F` unchanged.
- `next_pc = 0x3400` (jump target) for one cycle -> the next `PC_F = 0x3400`. The delay-slot instruction at the old `PC_F + 4` still reaches D with `valid_D = 1`.
- With `FETCH_EXC_EN`, drive `next_pc = 0x3002` -> the next cycle has `exc_code_D = 4`, `instr_D = 0`, `PC_D = 0x3002`. With `next_pc = 0x0000_0100`, `exc_code_D = 4`. Without the macro, `exc_code_D = 0` in both cases.
- Reset asserted during a stall at `PC_F = 0x3020` -> next cycle `PC_F = 0x3000`, `valid_D = 0`, `exc_code_D = 0`.
